// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM state encoding, reset defaults and
// RISC-V opcode constants used by fetch, decode and branch logic.
package core_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-pc select.
//   clk        core clock
//   rst_n      async active-low reset, loads RESET_PC
//   inc_i      advance pc by one word
//   redirect_i load word-aligned target (wins over inc_i)
//   target_i   redirect target, low two bits ignored
//   pc_o       current pc
module pc_reg
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i & ~XLEN'(3);
        end else if (inc_i) begin
            // wraps modulo 2^XLEN
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC & ~XLEN'(3);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request at a time, fetched
// word handed to decode over valid/ready, redirect from execute squashes.
//   clk, rst_n                     clock, async active-low reset
//   br_taken, br_target            redirect pulse and target
//   imem_req_valid/ready, imem_addr request channel
//   imem_rsp_valid, imem_rsp_data  response channel (no backpressure)
//   inst_valid/ready, inst, inst_pc decode handshake
//
// state | meaning
// REQ   | request presented on imem, waiting for imem_req_ready
// WAIT  | request accepted, waiting for response (drop_q: discard it)
// HOLD  | instruction presented to decode, waiting for inst_ready
module fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    fetch_state_t    state_q, state_d;
    logic            drop_q, drop_d;
    logic            req_valid_q, req_valid_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [XLEN-1:0] pc;
    logic            pc_inc;
    logic            pc_redirect;
    logic            req_accept;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (pc_inc),
        .redirect_i (pc_redirect),
        .target_i   (br_target),
        .pc_o       (pc)
    );

    // req_valid_q lags the state by the first cycle out of reset
    assign req_accept = (state_q == REQ) && req_valid_q && imem_req_ready;

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        pc_inc       = 1'b0;
        pc_redirect  = 1'b0;

        if (br_taken) begin
            pc_redirect  = 1'b1;
            inst_valid_d = 1'b0;
            case (state_q)
                REQ: begin
                    // an accepted request still owes us a response
                    if (req_accept) begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = REQ;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (req_accept) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            inst_d       = imem_rsp_data;
                            inst_pc_d    = pc;
                            inst_valid_d = 1'b1;
                            pc_inc       = 1'b1;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (inst_valid_q && inst_ready) begin
                        inst_valid_d = 1'b0;
                        state_d      = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end

        req_valid_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= REQ;
            drop_q       <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = req_valid_q ? pc : '0;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

`ifndef SYNTHESIS
    // a response outside WAIT is a memory protocol error and is ignored
    rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (state_q == WAIT));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst_n;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int          n_checks;
    int          n_errors;
    int          rsp_delay;
    int          acc_count;
    logic [31:0] last_acc;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'hFFFF_FFFC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory: accepts when ready, answers data=addr^K after 1+rsp_delay cycles
    initial begin
        logic        pend;
        logic [31:0] paddr;
        int          cnt;
        pend = 1'b0; paddr = '0; cnt = 0;
        acc_count = 0; last_acc = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk); #2;
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = paddr ^ K;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready && !pend) begin
                pend = 1'b1;
                paddr = imem_addr;
                cnt = rsp_delay;
                acc_count++;
                last_acc = imem_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
        n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL rst_addr got %h want 00000000", imem_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL rst_inst_valid got %b want 0", inst_valid); end
        n_checks++; if (inst !== 32'h0) begin n_errors++; $display("FAIL rst_inst got %h want 00000000", inst); end
        n_checks++; if (inst_pc !== 32'h0) begin n_errors++; $display("FAIL rst_inst_pc got %h want 00000000", inst_pc); end
        tick();
        rst_n = 1'b1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL rel_req_valid got %b want 0", imem_req_valid); end
        tick();
        n_checks++; if (imem_req_valid !== 1'b1) begin n_errors++; $display("FAIL first_req_valid got %b want 1", imem_req_valid); end
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL first_addr got %h want fffffffc", imem_addr); end
    endtask

    task automatic test_stream();
        tick();
        n_checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_errors++; $display("FAIL wait_idle got req=%b iv=%b want 0 0", imem_req_valid, inst_valid); end
        tick();
        n_checks++; if (inst_valid !== 1'b1) begin n_errors++; $display("FAIL inst0_valid got %b want 1", inst_valid); end
        n_checks++; if (inst_pc !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL inst0_pc got %h want fffffffc", inst_pc); end
        n_checks++; if (inst !== 32'h5A5A_5A59) begin n_errors++; $display("FAIL inst0_data got %h want 5a5a5a59", inst); end
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_errors++; $display("FAIL wrap_addr got v=%b %h want 1 00000000", imem_req_valid, imem_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL inst0_drop got %b want 0", inst_valid); end
        inst_ready = 1'b0;
    endtask

    task automatic test_hold();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (inst_valid !== 1'b1 || inst !== 32'hA5A5_A5A5 || inst_pc !== 32'h0) begin n_errors++; $display("FAIL hold_%0d got v=%b %h @%h want 1 a5a5a5a5 @00000000", i, inst_valid, inst, inst_pc); end
            n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL hold_noreq_%0d got %b want 0", i, imem_req_valid); end
            if (i == 4) inst_ready = 1'b1;
            tick();
        end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin n_errors++; $display("FAIL addr4 got v=%b %h want 1 00000004", imem_req_valid, imem_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL hold_release got %b want 0", inst_valid); end
        tick(); tick();
        n_checks++; if (inst_valid !== 1'b1 || inst !== 32'hA5A5_A5A1 || inst_pc !== 32'h4) begin n_errors++; $display("FAIL inst4 got v=%b %h @%h want 1 a5a5a5a1 @00000004", inst_valid, inst, inst_pc); end
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin n_errors++; $display("FAIL addr8 got v=%b %h want 1 00000008", imem_req_valid, imem_addr); end
        tick(); tick();
        n_checks++; if (inst_valid !== 1'b1 || inst !== 32'hA5A5_A5AD || inst_pc !== 32'h8) begin n_errors++; $display("FAIL inst8 got v=%b %h @%h want 1 a5a5a5ad @00000008", inst_valid, inst, inst_pc); end
    endtask

    task automatic test_redirect_wait();
        rsp_delay = 1;
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin n_errors++; $display("FAIL addrC got v=%b %h want 1 0000000c", imem_req_valid, imem_addr); end
        tick();
        br_taken = 1'b1; br_target = 32'h0000_0103;
        tick();
        br_taken = 1'b0;
        rsp_delay = 0;
        n_checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_errors++; $display("FAIL rw_waiting got req=%b iv=%b want 0 0", imem_req_valid, inst_valid); end
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin n_errors++; $display("FAIL rw_target got v=%b %h want 1 00000100", imem_req_valid, imem_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL rw_dropped got %b want 0", inst_valid); end
        tick(); tick();
        n_checks++; if (inst_valid !== 1'b1 || inst !== 32'hA5A5_A4A5 || inst_pc !== 32'h100) begin n_errors++; $display("FAIL rw_inst got v=%b %h @%h want 1 a5a5a4a5 @00000100", inst_valid, inst, inst_pc); end
    endtask

    task automatic test_redirect_hold();
        br_taken = 1'b1; br_target = 32'h0000_0200;
        tick();
        br_taken = 1'b0;
        n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL rh_squash got %b want 0", inst_valid); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin n_errors++; $display("FAIL rh_target got v=%b %h want 1 00000200", imem_req_valid, imem_addr); end
        tick(); tick();
        n_checks++; if (inst_valid !== 1'b1 || inst !== 32'hA5A5_A7A5 || inst_pc !== 32'h200) begin n_errors++; $display("FAIL rh_inst got v=%b %h @%h want 1 a5a5a7a5 @00000200", inst_valid, inst, inst_pc); end
    endtask

    task automatic test_stall_redirect();
        int acc0;
        imem_req_ready = 1'b0;
        tick();
        acc0 = acc_count;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h204) begin n_errors++; $display("FAIL st_c1 got v=%b %h want 1 00000204", imem_req_valid, imem_addr); end
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h204) begin n_errors++; $display("FAIL st_c2 got v=%b %h want 1 00000204", imem_req_valid, imem_addr); end
        br_taken = 1'b1; br_target = 32'h0000_0040;
        tick();
        br_taken = 1'b0;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin n_errors++; $display("FAIL st_c3 got v=%b %h want 1 00000040", imem_req_valid, imem_addr); end
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin n_errors++; $display("FAIL st_c4 got v=%b %h want 1 00000040", imem_req_valid, imem_addr); end
        imem_req_ready = 1'b1;
        tick();
        n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL st_accepted got %b want 0", imem_req_valid); end
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst !== 32'hA5A5_A5E5 || inst_pc !== 32'h40) begin n_errors++; $display("FAIL st_inst got v=%b %h @%h want 1 a5a5a5e5 @00000040", inst_valid, inst, inst_pc); end
        n_checks++; if (acc_count - acc0 != 1 || last_acc !== 32'h40) begin n_errors++; $display("FAIL st_fetched got n=%0d last=%h want 1 00000040", acc_count - acc0, last_acc); end
    endtask

    task automatic test_redirect_accept();
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h44) begin n_errors++; $display("FAIL ra_addr got v=%b %h want 1 00000044", imem_req_valid, imem_addr); end
        br_taken = 1'b1; br_target = 32'h0000_0080;
        tick();
        br_taken = 1'b0;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL ra_wait got %b want 0", imem_req_valid); end
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h80 || inst_valid !== 1'b0) begin n_errors++; $display("FAIL ra_target got v=%b %h iv=%b want 1 00000080 0", imem_req_valid, imem_addr, inst_valid); end
        tick(); tick();
        n_checks++; if (inst_valid !== 1'b1 || inst !== 32'hA5A5_A525 || inst_pc !== 32'h80) begin n_errors++; $display("FAIL ra_inst got v=%b %h @%h want 1 a5a5a525 @00000080", inst_valid, inst, inst_pc); end
    endtask

    task automatic test_reset_mid_wait();
        rsp_delay = 3;
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h84) begin n_errors++; $display("FAIL rm_addr got v=%b %h want 1 00000084", imem_req_valid, imem_addr); end
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin n_errors++; $display("FAIL rm_ctl got v=%b %h iv=%b want 0 00000000 0", imem_req_valid, imem_addr, inst_valid); end
        n_checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin n_errors++; $display("FAIL rm_data got %h @%h want 00000000 @00000000", inst, inst_pc); end
        tick(); tick();
        rsp_delay = 0;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL rm_restart got v=%b %h want 1 fffffffc", imem_req_valid, imem_addr); end
        tick(); tick();
        n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h5A5A_5A59 || inst_pc !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL rm_inst got v=%b %h @%h want 1 5a5a5a59 @fffffffc", inst_valid, inst, inst_pc); end
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_errors++; $display("FAIL rm_wrap got v=%b %h want 1 00000000", imem_req_valid, imem_addr); end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rsp_delay      = 0;
        rst_n          = 1'b0;
        br_taken       = 1'b0;
        br_target      = '0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;

        test_reset();
        test_stream();
        test_hold();
        test_redirect_wait();
        test_redirect_hold();
        test_stall_redirect();
        test_redirect_accept();
        test_reset_mid_wait();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
